// File: rtl/scroll_msg_display.sv
// Scrolling-message engine for multiplexed 7-segment displays: message buffer,
// blanked anode refresh, debounced manual stepping and timed auto-scroll.
module scroll_msg_display #(
  parameter int         NUM_DIGITS  = 4,
  parameter int         MSG_LEN     = 16,
  parameter int         REFRESH_DIV = 1024,
  parameter int         SCROLL_DIV  = 25_000_000,
  parameter int         DEB_CYCLES  = 500_000,
  parameter logic [5:0] BLANK       = 6'h3F,
  localparam int        OW          = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step_btn,
  input  logic                  auto_mode,
  input  logic                  dir,
  input  logic                  msg_we,
  input  logic [OW-1:0]         msg_addr,
  input  logic [5:0]            msg_data,
  output logic [NUM_DIGITS-1:0] an,
  output logic [5:0]            char,
  output logic [OW-1:0]         offset
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int TW = $clog2(SCROLL_DIV);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [SW-1:0] SLOT_LAST = SW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] SCR_LAST  = TW'(SCROLL_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [OW-1:0] OFF_LAST  = OW'(MSG_LEN - 1);
  localparam logic [OW:0]   LEN_W     = (OW+1)'(MSG_LEN);

  logic [SW-1:0] slot_q, slot_d;
  logic [DW-1:0] digit_q, digit_d;
  logic [5:0]    char_q, char_d;
  logic [5:0]    msg_q [MSG_LEN];
  logic [5:0]    msg_d [MSG_LEN];
  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d, deb_prev_q;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic          auto_prev_q;
  logic [TW-1:0] scr_q, scr_d;
  logic [OW-1:0] offset_q, offset_d;

  logic [OW:0]   rd_sum;
  logic [OW-1:0] rd_idx;
  logic          step_pulse;
  logic          step;

  always_comb begin
    slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
    digit_d = digit_q;
    if (slot_q == SLOT_LAST) begin
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DW'(1);
    end

    // Leftmost digit (highest index) shows msg[offset]; the sum never reaches 2*MSG_LEN.
    rd_sum = {1'b0, offset_q} + (OW+1)'(NUM_DIGITS - 1) - (OW+1)'(digit_q);
    rd_idx = (rd_sum >= LEN_W) ? OW'(rd_sum - LEN_W) : OW'(rd_sum);

    char_d = char_q;
    if (slot_q == '0) begin
      char_d = msg_q[rd_idx];
    end

    msg_d = msg_q;
    if (msg_we && ({1'b0, msg_addr} < LEN_W)) begin
      msg_d[msg_addr] = msg_data;
    end

    an = '1;
    if ((slot_q != '0) && (slot_q != SLOT_LAST)) begin
      an[digit_q] = 1'b0;
    end

    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = ~deb_q;
      end else begin
        deb_cnt_d = deb_cnt_q + CW'(1);
      end
    end
    step_pulse = deb_q & ~deb_prev_q;

    // A mode change restarts the scroll timer and swallows any step in that cycle.
    step  = 1'b0;
    scr_d = '0;
    if (auto_mode == auto_prev_q) begin
      if (auto_mode) begin
        if (scr_q == SCR_LAST) begin
          step = 1'b1;
        end else begin
          scr_d = scr_q + TW'(1);
        end
      end else begin
        step = step_pulse;
      end
    end

    offset_d = offset_q;
    if (step) begin
      if (dir) begin
        offset_d = (offset_q == '0) ? OFF_LAST : offset_q - OW'(1);
      end else begin
        offset_d = (offset_q == OFF_LAST) ? '0 : offset_q + OW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q      <= '0;
      digit_q     <= '0;
      char_q      <= BLANK;
      for (int i = 0; i < MSG_LEN; i++) begin
        msg_q[i] <= BLANK;
      end
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_q       <= 1'b0;
      deb_prev_q  <= 1'b0;
      deb_cnt_q   <= '0;
      auto_prev_q <= 1'b0;
      scr_q       <= '0;
      offset_q    <= '0;
    end else begin
      slot_q      <= slot_d;
      digit_q     <= digit_d;
      char_q      <= char_d;
      msg_q       <= msg_d;
      sync1_q     <= step_btn;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_q;
      deb_cnt_q   <= deb_cnt_d;
      auto_prev_q <= auto_mode;
      scr_q       <= scr_d;
      offset_q    <= offset_d;
    end
  end

  assign char   = char_q;
  assign offset = offset_q;

endmodule

// File: tb/tb_scroll_msg_display.sv
// Self-checking bench for scroll_msg_display: per-cycle reference model plus
// directed press/bounce/auto/reset sequences and a step table.
module tb_scroll_msg_display;

  localparam int         ND  = 4;
  localparam int         ML  = 6;
  localparam int         RD  = 8;
  localparam int         SD  = 40;
  localparam int         DEB = 5;
  localparam logic [5:0] BL  = 6'h3F;

  logic       clk = 1'b0;
  logic       reset;
  logic       step_btn;
  logic       auto_mode;
  logic       dir;
  logic       msg_we;
  logic [2:0] msg_addr;
  logic [5:0] msg_data;
  logic [3:0] an;
  logic [5:0] char;
  logic [2:0] offset;

  always #5 clk = ~clk;

  scroll_msg_display #(
    .NUM_DIGITS (ND),
    .MSG_LEN    (ML),
    .REFRESH_DIV(RD),
    .SCROLL_DIV (SD),
    .DEB_CYCLES (DEB),
    .BLANK      (BL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .step_btn (step_btn),
    .auto_mode(auto_mode),
    .dir      (dir),
    .msg_we   (msg_we),
    .msg_addr (msg_addr),
    .msg_data (msg_data),
    .an       (an),
    .char     (char),
    .offset   (offset)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: cycle count since reset gives slot and digit directly.
  logic [5:0] m_msg [ML];
  logic [5:0] m_char;
  int         m_off, m_t, m_n, m_A, m_run;
  logic       m_s1, m_s2, m_level, m_pend, m_auto_prev;
  logic [5:0] disp [ND];

  typedef struct {
    logic d;
    int   exp_off;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_an();
    int slot = m_t % RD;
    int dg   = (m_t / RD) % ND;
    if (slot >= 1 && slot <= RD - 2) return ~(4'b0001 << dg);
    return 4'hF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ML; i++) m_msg[i] = BL;
    m_char = BL; m_off = 0; m_t = 0; m_n = 0; m_A = 0; m_run = 0;
    m_s1 = 0; m_s2 = 0; m_level = 0; m_pend = 0; m_auto_prev = 0;
  endtask

  // Advance model across one clock edge using the currently driven inputs, then compare.
  task automatic tick();
    logic step;
    int   slot, dg;
    slot = m_t % RD;
    dg   = (m_t / RD) % ND;
    step = 1'b0;
    if (slot == 0) m_char = m_msg[(m_off + ND - 1 - dg) % ML];
    if (auto_mode != m_auto_prev) begin
      if (auto_mode) m_A = m_n;
    end else if (auto_mode) begin
      step = ((m_n - m_A) % SD) == 0;
    end else begin
      step = m_pend;
    end
    m_pend = 1'b0;
    if (m_s2 == m_level) m_run = 0;
    else begin
      m_run++;
      if (m_run == DEB) begin
        m_level = ~m_level;
        m_run   = 0;
        m_pend  = m_level;
      end
    end
    m_s2 = m_s1;
    m_s1 = step_btn;
    if (msg_we && msg_addr < ML) m_msg[msg_addr] = msg_data;
    if (step) m_off = dir ? (m_off + ML - 1) % ML : (m_off + 1) % ML;
    m_auto_prev = auto_mode;
    m_t++;
    m_n++;
    @(posedge clk);
    #1;
    check("an", an, exp_an());
    check("char", char, m_char);
    check("offset", offset, m_off);
  endtask

  task automatic hold_btn(input logic v, input int n);
    step_btn = v;
    repeat (n) tick();
  endtask

  task automatic capture(input int n);
    for (int k = 0; k < ND; k++) disp[k] = 6'h2A;
    repeat (n) begin
      tick();
      for (int k = 0; k < ND; k++) if (an[k] == 1'b0) disp[k] = char;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int changes, prev, wrapped, run_left, found;
    tbl[0] = '{1'b1, 1};
    tbl[1] = '{1'b1, 0};
    tbl[2] = '{1'b1, 5};
    tbl[3] = '{1'b0, 0};
    tbl[4] = '{1'b0, 1};
    tbl[5] = '{1'b1, 0};

    reset = 1; step_btn = 0; auto_mode = 0; dir = 0;
    msg_we = 0; msg_addr = 0; msg_data = 0;
    #2;
    check("rst_an", an, 4'hF);
    check("rst_char", char, BL);
    check("rst_offset", offset, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    model_reset();

    // Idle after reset: every slot shows BLANK.
    capture(ND * RD);
    for (int k = 0; k < ND; k++) check("idle_blank", disp[k], BL);

    for (int a = 0; a < ML; a++) begin
      msg_we = 1; msg_addr = 3'(a); msg_data = 6'(a);
      tick();
    end
    msg_addr = 3'd6; msg_data = 6'h00;
    tick();
    msg_we = 0;
    repeat (4) tick();

    // Offset moves on the 8th edge after the press is driven (7 after it is first sampled).
    step_btn = 1;
    repeat (7) tick();
    check("press_early", offset, 0);
    tick();
    check("press_step", offset, 1);
    repeat (2) tick();
    hold_btn(0, 12);
    repeat (40) tick();
    capture(ND * RD);
    check("disp_l0", disp[3], 1);
    check("disp_l1", disp[2], 2);
    check("disp_l2", disp[1], 3);
    check("disp_l3", disp[0], 4);

    for (int r = 0; r < 5; r++) begin
      hold_btn(1, 3);
      hold_btn(0, 3);
    end
    check("bounce_nostep", offset, 1);
    hold_btn(1, 12);
    hold_btn(0, 12);
    check("bounce_onestep", offset, 2);

    for (int i = 0; i < 6; i++) begin
      dir = tbl[i].d;
      hold_btn(1, 10);
      hold_btn(0, 12);
      check("table_step", offset, tbl[i].exp_off);
    end

    dir = 1;
    hold_btn(1, 10);
    hold_btn(0, 12);
    check("back_wrap", offset, 5);
    repeat (40) tick();
    capture(ND * RD);
    check("wrap_l0", disp[3], 5);
    check("wrap_l1", disp[2], 0);
    check("wrap_l2", disp[1], 1);
    check("wrap_l3", disp[0], 2);

    dir = 0; auto_mode = 1;
    changes = 0; wrapped = 0; prev = offset;
    for (int i = 0; i < 260; i++) begin
      if (i == 60 || i == 150) step_btn = 1;
      if (i == 72 || i == 162) step_btn = 0;
      tick();
      if (offset != prev) begin
        changes++;
        if (prev == 5 && offset == 0) wrapped = 1;
      end
      prev = offset;
    end
    check("auto_steps", changes, 6);
    check("auto_wrap", wrapped, 1);
    auto_mode = 0;
    repeat (20) tick();

    run_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run_left == 0) begin
        step_btn = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 12);
      end
      run_left--;
      msg_we   = ($urandom_range(0, 3) == 0);
      msg_addr = 3'($urandom_range(0, 7));
      msg_data = 6'($urandom);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if ($urandom_range(0, 299) == 0) auto_mode = ~auto_mode;
      tick();
    end
    msg_we = 0; auto_mode = 0; step_btn = 0; dir = 0;
    repeat (20) tick();
    if (m_off == 0) begin
      hold_btn(1, 10);
      hold_btn(0, 12);
    end

    found = 0;
    for (int i = 0; i < 64 && found == 0; i++) begin
      tick();
      if (an == 4'b1011) found = 1;
    end
    check("find_an2", found, 1);
    #2;
    reset = 1;
    #1;
    check("mid_rst_an", an, 4'hF);
    check("mid_rst_char", char, BL);
    check("mid_rst_offset", offset, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    repeat (ND * RD) tick();
    capture(ND * RD);
    for (int k = 0; k < ND; k++) check("cleared_blank", disp[k], BL);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
